// File: rtl/memory_cycle.sv
// Memory-access pipeline stage: word-addressed data RAM with a fixed multi-cycle
// access latency, upstream stall while busy, and registered write-back outputs.
module memory_cycle #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] aluin,
    input  logic [DATA_W-1:0] bin,
    input  logic [3:0]        rdin,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              regwrite,
    input  logic              memtoreg,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] wbdata,
    output logic [3:0]        rdout,
    output logic              regwriteout,
    output logic              err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [3:0]          rd_q, rd_d;
    logic                rw_q, rw_d;
    logic                mtr_q, mtr_d;
    logic                st_q, st_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    logic                regwriteout_q, regwriteout_d;
    logic [DATA_W-1:0]   wbdata_q, wbdata_d;
    logic [3:0]          rdout_q, rdout_d;
    logic                mem_we;
    logic [DATA_W-1:0]   ram_rdata;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Upper address bits are dropped, so addresses wrap onto the RAM depth.
    assign ram_rdata = mem_q[alu_q[ADDR_W-1:0]];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_d         = alu_q;
        bin_d         = bin_q;
        rd_d          = rd_q;
        rw_d          = rw_q;
        mtr_d         = mtr_q;
        st_d          = st_q;
        out_valid_d   = 1'b0;
        err_d         = 1'b0;
        regwriteout_d = 1'b0;
        wbdata_d      = wbdata_q;
        rdout_d       = rdout_q;
        mem_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (memread && memwrite) begin
                        out_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else if (memread || memwrite) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                        alu_d   = aluin;
                        bin_d   = bin;
                        rd_d    = rdin;
                        rw_d    = regwrite;
                        mtr_d   = memtoreg;
                        st_d    = memwrite;
                    end else begin
                        out_valid_d   = 1'b1;
                        wbdata_d      = aluin;
                        rdout_d       = rdin;
                        regwriteout_d = regwrite;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d       = IDLE;
                    out_valid_d   = 1'b1;
                    rdout_d       = rd_q;
                    regwriteout_d = rw_q;
                    wbdata_d      = mtr_q ? ram_rdata : alu_q;
                    // Gate with reset so an access aborted by reset never commits.
                    mem_we        = st_q & rst;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            regwriteout_q <= 1'b0;
            wbdata_q      <= '0;
            rdout_q       <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            err_q         <= err_d;
            regwriteout_q <= regwriteout_d;
            wbdata_q      <= wbdata_d;
            rdout_q       <= rdout_d;
        end
    end

    always_ff @(posedge clk) begin
        alu_q <= alu_d;
        bin_q <= bin_d;
        rd_q  <= rd_d;
        rw_q  <= rw_d;
        mtr_q <= mtr_d;
        st_q  <= st_d;
    end

    // RAM contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[alu_q[ADDR_W-1:0]] <= bin_q;
        end
    end

    assign stall       = (state_q == BUSY);
    assign out_valid   = out_valid_q;
    assign err         = err_q;
    assign regwriteout = regwriteout_q;
    assign wbdata      = wbdata_q;
    assign rdout       = rdout_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: two instances (latency 2 and 3) share stimulus and are
// each checked every cycle against an occupancy-count behavioural model.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] aluin = '0;
    logic [15:0] bin = '0;
    logic [3:0]  rdin = '0;
    logic        memread = 1'b0, memwrite = 1'b0, regwrite = 1'b0, memtoreg = 1'b0;

    logic [1:0]  stall_o, vld_o, rw_o, err_o;
    logic [15:0] wb_o [2];
    logic [3:0]  rd_o [2];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    memory_cycle #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .aluin(aluin), .bin(bin), .rdin(rdin),
        .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
        .stall(stall_o[0]), .out_valid(vld_o[0]), .wbdata(wb_o[0]), .rdout(rd_o[0]),
        .regwriteout(rw_o[0]), .err(err_o[0]));

    memory_cycle #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .aluin(aluin), .bin(bin), .rdin(rdin),
        .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
        .stall(stall_o[1]), .out_valid(vld_o[1]), .wbdata(wb_o[1]), .rdout(rd_o[1]),
        .regwriteout(rw_o[1]), .err(err_o[1]));

    // Behavioural model: cycles of occupancy left, pending op, and expected outputs.
    int          lat [2] = '{2, 3};
    int          m_busy [2] = '{0, 0};
    logic [15:0] m_mem [2][256];
    logic [15:0] p_alu [2], p_bin [2];
    logic [3:0]  p_rd [2];
    logic        p_st [2], p_rw [2], p_mtr [2];
    logic        e_vld [2], e_err [2], e_rw [2];
    logic [15:0] e_wb [2];
    logic [3:0]  e_rd [2];

    task automatic model_reset(int k);
        m_busy[k] = 0;
        e_vld[k] = 1'b0; e_err[k] = 1'b0; e_rw[k] = 1'b0;
        e_wb[k] = 16'h0; e_rd[k] = 4'h0;
    endtask

    task automatic model_edge(int k);
        logic [7:0]  a;
        logic [15:0] word;
        e_vld[k] = 1'b0; e_err[k] = 1'b0; e_rw[k] = 1'b0;
        if (m_busy[k] > 0) begin
            m_busy[k]--;
            if (m_busy[k] == 0) begin
                a = p_alu[k][7:0];
                word = m_mem[k][a];
                if (p_st[k]) m_mem[k][a] = p_bin[k];
                e_vld[k] = 1'b1;
                e_rw[k]  = p_rw[k];
                e_rd[k]  = p_rd[k];
                e_wb[k]  = p_mtr[k] ? word : p_alu[k];
            end
        end else if (in_valid) begin
            if (memread && memwrite) begin
                e_vld[k] = 1'b1;
                e_err[k] = 1'b1;
            end else if (memread || memwrite) begin
                m_busy[k] = lat[k];
                p_alu[k] = aluin; p_bin[k] = bin; p_rd[k] = rdin;
                p_st[k] = memwrite; p_rw[k] = regwrite; p_mtr[k] = memtoreg;
            end else begin
                e_vld[k] = 1'b1;
                e_wb[k]  = aluin;
                e_rd[k]  = rdin;
                e_rw[k]  = regwrite;
            end
        end
    endtask

    always @(negedge rst) begin
        model_reset(0);
        model_reset(1);
    end

    always @(posedge clk) begin
        if (rst) begin
            model_edge(0);
            model_edge(1);
        end
    end

    // Per-instance observations used by the directed literal checks.
    int          pulse_cnt [2] = '{0, 0};
    int          stall_cnt [2] = '{0, 0};
    logic [15:0] seen_wb [2];
    logic [3:0]  seen_rd [2];
    logic        seen_rw [2], seen_err [2];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (stall_o[k] !== (m_busy[k] > 0) || vld_o[k] !== e_vld[k] ||
                    err_o[k] !== e_err[k] || rw_o[k] !== e_rw[k] ||
                    wb_o[k] !== e_wb[k] || rd_o[k] !== e_rd[k]) begin
                    fails++;
                    $display("FAIL cycle dut%0d t=%0t: got stall=%0b vld=%0b err=%0b rw=%0b wb=%h rd=%h, required stall=%0b vld=%0b err=%0b rw=%0b wb=%h rd=%h",
                             k, $time, stall_o[k], vld_o[k], err_o[k], rw_o[k], wb_o[k], rd_o[k],
                             (m_busy[k] > 0), e_vld[k], e_err[k], e_rw[k], e_wb[k], e_rd[k]);
                end
                if (vld_o[k] === 1'b1) begin
                    pulse_cnt[k]++;
                    seen_wb[k] = wb_o[k]; seen_rd[k] = rd_o[k];
                    seen_rw[k] = rw_o[k]; seen_err[k] = err_o[k];
                end
                if (stall_o[k] === 1'b1) stall_cnt[k]++;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Presents one op for one accept edge, then waits until both instances are idle;
    // in_valid is toggled with junk while both are busy, which must be ignored.
    task automatic issue(logic [15:0] a, logic [15:0] b, logic [3:0] rd,
                         logic mr, logic mw, logic rw, logic mtr);
        int n;
        pulse_cnt = '{0, 0};
        stall_cnt = '{0, 0};
        aluin = a; bin = b; rdin = rd; memread = mr; memwrite = mw;
        regwrite = rw; memtoreg = mtr; in_valid = 1'b1;
        @(negedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while ((m_busy[0] > 0 || m_busy[1] > 0) && n < 50) begin
            aluin = 16'($urandom); bin = 16'($urandom); rdin = 4'($urandom);
            memread = 1'($urandom); memwrite = 1'($urandom);
            regwrite = 1'($urandom); memtoreg = 1'($urandom);
            in_valid = (m_busy[0] > 0 && m_busy[1] > 0) ? 1'($urandom) : 1'b0;
            @(negedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("op_completes_in_budget", 32'(n < 50), 32'd1);
    endtask

    initial begin
        #2 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_stall", 32'(stall_o[k]), 0);
            check("reset_out_valid", 32'(vld_o[k]), 0);
            check("reset_wbdata", 32'(wb_o[k]), 0);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;

        // ALU pass-through
        issue(16'h0003, 16'h0000, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            check("alu_pulses", 32'(pulse_cnt[k]), 1);
            check("alu_no_stall", 32'(stall_cnt[k]), 0);
            check("alu_wbdata", 32'(seen_wb[k]), 32'h0003);
            check("alu_rdout", 32'(seen_rd[k]), 4);
            check("alu_regwrite", 32'(seen_rw[k]), 1);
        end

        // Fill RAM with a known pattern: word i = {i, ~i}
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            issue({8'h00, ib}, {ib, ~ib}, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Store then load
        issue(16'h0010, 16'hBEEF, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("store_stall_lat2", 32'(stall_cnt[0]), 2);
        check("store_stall_lat3", 32'(stall_cnt[1]), 3);
        issue(16'h0010, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            check("load_after_store_wb", 32'(seen_wb[k]), 32'hBEEF);
            check("load_after_store_rd", 32'(seen_rd[k]), 7);
        end
        check("load_stall_lat2", 32'(stall_cnt[0]), 2);

        // Address wrap
        issue(16'h0105, 16'h1234, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(16'h0005, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) check("wrap_load_wb", 32'(seen_wb[k]), 32'h1234);

        // Latency 3 load with in_valid toggled while busy
        issue(16'h0042, 16'h0000, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        check("lat3_stall_cycles", 32'(stall_cnt[1]), 3);
        check("lat3_single_pulse", 32'(pulse_cnt[1]), 1);
        check("lat3_load_wb", 32'(seen_wb[1]), 32'h42BD);

        // Illegal op leaves RAM untouched
        issue(16'h0030, 16'hDEAD, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            check("illegal_err", 32'(seen_err[k]), 1);
            check("illegal_regwrite", 32'(seen_rw[k]), 0);
            check("illegal_no_stall", 32'(stall_cnt[k]), 0);
        end
        issue(16'h0030, 16'h0000, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) check("illegal_ram_kept", 32'(seen_wb[k]), 32'h30CF);

        // Reset during a store
        aluin = 16'h0020; bin = 16'hAAAA; rdin = 4'd8;
        memread = 1'b0; memwrite = 1'b1; regwrite = 1'b1; memtoreg = 1'b0; in_valid = 1'b1;
        @(negedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("midop_reset_stall", 32'(stall_o[k]), 0);
            check("midop_reset_valid", 32'(vld_o[k]), 0);
            check("midop_reset_wb", 32'(wb_o[k]), 0);
            check("midop_reset_rd", 32'(rd_o[k]), 0);
            check("midop_reset_rw", 32'(rw_o[k]), 0);
            check("midop_reset_err", 32'(err_o[k]), 0);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        issue(16'h0020, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) check("aborted_store_wb", 32'(seen_wb[k]), 32'h20DF);

        // Random traffic; each instance accepts independently against its own model
        for (int c = 0; c < 2500; c++) begin
            int kind;
            kind = int'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            aluin = 16'($urandom); bin = 16'($urandom); rdin = 4'($urandom);
            regwrite = 1'($urandom);
            memread  = (kind == 3 || kind == 4 || kind == 7);
            memwrite = (kind == 5 || kind == 6 || kind == 7);
            memtoreg = (memwrite && !memread) ? 1'b0 : 1'($urandom);
            @(negedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
